// File: rtl/pulse_phase_scanner.sv
// Phase-select sequencer for the 320 MHz pulse generator: walks the enabled
// phases of a latched mask in ascending order, firing nPulse selects per phase.
`timescale 1ns/1ps

module pulse_phase_scanner #(
  parameter int NPULSE_W = 8,
  parameter int GAP_W    = 8
) (
  input  logic                  CLK40M,
  input  logic                  RSTn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [7:0]            phaseMask,
  input  logic [NPULSE_W-1:0]   nPulse,
  input  logic [GAP_W-1:0]      gap,
  output logic [7:0]            s,
  output logic                  fire,
  output logic [2:0]            curPhase,
  output logic [NPULSE_W+2:0]   totalCnt,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FIRE = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]          state;
  logic [7:0]          mask_q;
  logic [NPULSE_W-1:0] npulse_q;
  logic [GAP_W-1:0]    gap_q;
  logic [GAP_W-1:0]    gap_cnt;
  logic [NPULSE_W-1:0] phase_cnt;

  logic [2:0]          first_phase;
  logic [2:0]          next_phase;
  logic                has_next;
  logic [NPULSE_W-1:0] phase_cnt_inc;
  logic                phase_complete;
  logic [2:0]          fire_phase;

  function automatic logic [7:0] onehot(input logic [2:0] p);
    return 8'h01 << p;
  endfunction

  // Lowest set bit of the incoming mask, and the next set bit of the latched
  // mask strictly above the current phase (descending loops keep the lowest).
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    first_phase = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (phaseMask[i]) first_phase = 3'(i);
    end
    next_phase = curPhase;
    has_next   = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(curPhase))) begin
        next_phase = 3'(i);
        has_next   = 1'b1;
      end
    end
  end

  assign phase_cnt_inc  = phase_cnt + 1'b1;
  assign phase_complete = (phase_cnt_inc == npulse_q);
  assign fire_phase     = phase_complete ? next_phase : curPhase;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge CLK40M) begin
    if (!RSTn) begin
      state     <= ST_IDLE;
      mask_q    <= '0;
      npulse_q  <= '0;
      gap_q     <= '0;
      gap_cnt   <= '0;
      phase_cnt <= '0;
      s         <= '0;
      fire      <= 1'b0;
      curPhase  <= '0;
      totalCnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // Strobe-like outputs default low; branches raise them as needed.
      s    <= '0;
      fire <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            totalCnt <= '0;
            if (phaseMask != 8'h00) begin
              mask_q    <= phaseMask;
              npulse_q  <= (nPulse == '0) ? NPULSE_W'(1) : nPulse;
              gap_q     <= gap;
              phase_cnt <= '0;
              curPhase  <= first_phase;
              s         <= onehot(first_phase);
              fire      <= 1'b1;
              busy      <= 1'b1;
              state     <= ST_FIRE;
            end else begin
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end
        end

        ST_FIRE: begin
          // The pulse of this cycle has been issued, so it counts even on abort.
          totalCnt <= totalCnt + 1'b1;
          if (abort) begin
            state <= ST_IDLE;
          end else if (phase_complete && !has_next) begin
            phase_cnt <= phase_cnt_inc;
            done      <= 1'b1;
            state     <= ST_DONE;
          end else begin
            if (phase_complete) begin
              curPhase  <= next_phase;
              phase_cnt <= '0;
            end else begin
              phase_cnt <= phase_cnt_inc;
            end
            busy <= 1'b1;
            if (gap_q != '0) begin
              gap_cnt <= gap_q;
              state   <= ST_GAP;
            end else begin
              s     <= onehot(fire_phase);
              fire  <= 1'b1;
              state <= ST_FIRE;
            end
          end
        end

        ST_GAP: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (gap_cnt <= GAP_W'(1)) begin
            s     <= onehot(curPhase);
            fire  <= 1'b1;
            busy  <= 1'b1;
            state <= ST_FIRE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
            busy    <= 1'b1;
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_phase_scanner.sv
// Self-checking bench for pulse_phase_scanner: each scan is predicted as a
// per-cycle list of select words built from the mask / count / gap rules.
`timescale 1ns/1ps

module tb_pulse_phase_scanner;

  logic        CLK40M = 1'b0;
  logic        RSTn;
  logic        start;
  logic        abort;
  logic [7:0]  phaseMask;
  logic [7:0]  nPulse;
  logic [7:0]  gap;
  logic [7:0]  s;
  logic        fire;
  logic [2:0]  curPhase;
  logic [10:0] totalCnt;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  pulse_phase_scanner #(.NPULSE_W(8), .GAP_W(8)) dut (
    .CLK40M    (CLK40M),
    .RSTn      (RSTn),
    .start     (start),
    .abort     (abort),
    .phaseMask (phaseMask),
    .nPulse    (nPulse),
    .gap       (gap),
    .s         (s),
    .fire      (fire),
    .curPhase  (curPhase),
    .totalCnt  (totalCnt),
    .busy      (busy),
    .done      (done)
  );

  always #12.5 CLK40M = ~CLK40M;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Runs one scan from IDLE. The expected trace lists, per cycle after the
  // start edge, the select word, the phase and whether it is the done cycle.
  // abort_at >= 0 raises abort so that it is sampled at the edge after that entry.
  task automatic run_scan(input logic [7:0] m, input logic [7:0] n,
                          input logic [7:0] g, input bit noisy, input int abort_at);
    logic [7:0] q_s[$];
    int         q_ph[$];
    bit         q_done[$];
    logic [7:0] one;
    int         n_eff, lastp, last_idx, exp_total;
    bit         exp_fire, exp_busy;

    n_eff = (n == 8'd0) ? 1 : int'(n);
    lastp = -1;
    for (int p = 0; p < 8; p++) if (m[p]) lastp = p;
    for (int p = 0; p < 8; p++) begin
      if (m[p]) begin
        one = 8'h01 << p;
        for (int k = 0; k < n_eff; k++) begin
          q_s.push_back(one); q_ph.push_back(p); q_done.push_back(1'b0);
          if (!(p == lastp && k == n_eff - 1)) begin
            for (int z = 0; z < int'(g); z++) begin
              q_s.push_back(8'h00); q_ph.push_back(p); q_done.push_back(1'b0);
            end
          end
        end
      end
    end
    q_s.push_back(8'h00); q_ph.push_back(0); q_done.push_back(1'b1);
    last_idx = (abort_at >= 0) ? abort_at : q_s.size() - 1;

    @(negedge CLK40M);
    phaseMask = m; nPulse = n; gap = g; start = 1'b1; abort = 1'b0;
    exp_total = 0;
    for (int j = 0; j <= last_idx; j++) begin
      @(posedge CLK40M); #1;
      exp_fire = (q_s[j] != 8'h00);
      exp_busy = !q_done[j];
      if (exp_fire) exp_total++;
      checks++;
      if ({s, fire, busy, done} !== {q_s[j], exp_fire, exp_busy, q_done[j]}) begin
        errors++;
        $display("FAIL scan m=%02h n=%0d g=%0d cycle %0d: s/fire/busy/done got %02h/%b/%b/%b want %02h/%b/%b/%b",
                 m, n, g, j, s, fire, busy, done, q_s[j], exp_fire, exp_busy, q_done[j]);
      end
      if (exp_fire) begin
        checks++;
        if (curPhase !== 3'(q_ph[j])) begin
          errors++;
          $display("FAIL curPhase m=%02h cycle %0d: got %0d want %0d", m, j, curPhase, q_ph[j]);
        end
      end
      @(negedge CLK40M);
      if (j == abort_at) abort = 1'b1;
      start = noisy && (j < q_s.size() - 1) && ((j == 1) || ($urandom_range(0, 1) == 1));
      if (noisy) begin
        phaseMask = 8'($urandom); nPulse = 8'($urandom); gap = 8'($urandom);
      end
    end

    // Back in IDLE: outputs quiet, count holds, no late done strobe.
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK40M); #1;
      checks++;
      if ({s, fire, busy, done} !== 11'd0 || totalCnt !== 11'(exp_total)) begin
        errors++;
        $display("FAIL idle m=%02h n=%0d g=%0d +%0d: s=%02h fire=%b busy=%b done=%b total=%0d want 0/0/0/0 total=%0d",
                 m, n, g, c, s, fire, busy, done, totalCnt, exp_total);
      end
      @(negedge CLK40M);
      start = 1'b0; abort = 1'b0;
    end
  endtask

  task automatic test_reset();
    RSTn = 1'b0; start = 1'b1; abort = 1'b1;
    phaseMask = 8'hFF; nPulse = 8'd3; gap = 8'd1;
    repeat (3) @(posedge CLK40M);
    #1;
    checks++;
    if ({s, fire, busy, done, curPhase, totalCnt} !== 25'd0) begin
      errors++;
      $display("FAIL reset: s=%02h fire=%b busy=%b done=%b ph=%0d total=%0d want all 0",
               s, fire, busy, done, curPhase, totalCnt);
    end
    @(negedge CLK40M);
    RSTn = 1'b1; start = 1'b0;
    // abort alone in IDLE does nothing.
    @(posedge CLK40M); #1;
    checks++;
    if ({s, fire, busy, done} !== 11'd0) begin
      errors++;
      $display("FAIL abort_idle: s=%02h fire=%b busy=%b done=%b want 0", s, fire, busy, done);
    end
    @(negedge CLK40M);
    abort = 1'b0;
  endtask

  task automatic test_basic();
    run_scan(8'h05, 8'd2, 8'd1, 1'b0, -1);
  endtask

  task automatic test_zero_count();
    run_scan(8'h80, 8'd0, 8'd0, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    run_scan(8'hFF, 8'd1, 8'd0, 1'b0, -1);
  endtask

  task automatic test_empty_mask();
    run_scan(8'h00, 8'd5, 8'd2, 1'b0, -1);
  endtask

  task automatic test_abort_gap();
    // Entries: 0 FIRE, 1-4 GAP, 5 FIRE, 6-7 GAP -> abort sampled after entry 7.
    run_scan(8'h03, 8'd3, 8'd4, 1'b1, 7);
    // start together with abort in IDLE is overridden.
    @(negedge CLK40M);
    phaseMask = 8'h01; nPulse = 8'd1; gap = 8'd0; start = 1'b1; abort = 1'b1;
    @(posedge CLK40M); #1;
    checks++;
    if ({s, fire, busy, done} !== 11'd0 || totalCnt !== 11'd2) begin
      errors++;
      $display("FAIL abort_start: s=%02h fire=%b busy=%b done=%b total=%0d want 0 total=2",
               s, fire, busy, done, totalCnt);
    end
    @(negedge CLK40M);
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset_mid_fire();
    @(negedge CLK40M);
    phaseMask = 8'h2C; nPulse = 8'd3; gap = 8'd2; start = 1'b1;
    @(posedge CLK40M); #1;
    checks++;
    if (fire !== 1'b1 || s !== 8'h04) begin
      errors++;
      $display("FAIL rst_fire_pre: fire=%b s=%02h want 1/04", fire, s);
    end
    @(negedge CLK40M);
    RSTn = 1'b0; start = 1'b1;
    @(posedge CLK40M); #1;
    checks++;
    if ({s, fire, busy, done, curPhase, totalCnt} !== 25'd0) begin
      errors++;
      $display("FAIL rst_fire: s=%02h fire=%b busy=%b done=%b ph=%0d total=%0d want all 0",
               s, fire, busy, done, curPhase, totalCnt);
    end
    @(negedge CLK40M);
    RSTn = 1'b1; start = 1'b0;
    @(posedge CLK40M); #1;
    checks++;
    if ({s, fire, busy, done} !== 11'd0) begin
      errors++;
      $display("FAIL rst_idle: s=%02h fire=%b busy=%b done=%b want 0", s, fire, busy, done);
    end
    run_scan(8'h2C, 8'd3, 8'd2, 1'b0, -1);
  endtask

  task automatic test_random();
    for (int t = 0; t < 12; t++) begin
      run_scan(8'($urandom), 8'($urandom_range(0, 4)), 8'($urandom_range(0, 3)), 1'b1, -1);
    end
  endtask

  task automatic test_max_count();
    run_scan(8'hFF, 8'd255, 8'd0, 1'b0, -1);
  endtask

  initial begin
    start = 1'b0; abort = 1'b0; RSTn = 1'b0;
    phaseMask = 8'h00; nPulse = 8'd0; gap = 8'd0;
    test_reset();
    test_basic();
    test_zero_count();
    test_back_to_back();
    test_empty_mask();
    test_abort_gap();
    test_reset_mid_fire();
    test_random();
    test_max_count();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
